// File: rtl/shared_adder_arb_pkg.sv
// Shared types and helpers for the shared adder arbiter.
// SHARED_ADDER_ARB_OVF_EN (optional define) adds a registered carry/overflow flag to responses.
package shared_adder_arb_pkg;

  localparam int ADDER_BRANCH_SHIFT = 1;

  // Generous upper bounds so the response record can be shared by any instance.
  localparam int RSP_ID_W_MAX   = 8;
  localparam int RSP_DATA_W_MAX = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic [RSP_ID_W_MAX-1:0]   id;
    logic [RSP_DATA_W_MAX-1:0] data;
    logic                      ovf;
  } rsp_rec_t;

  // A single requester would still need a one-bit ID field.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_add_core.sv
// Combinational adder with optional branch-offset shift on operand b.
// SHARED_ADDER_ARB_OVF_EN adds the carry output; otherwise no carry logic exists.
module arb_add_core
  import shared_adder_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             shift,
`ifdef SHARED_ADDER_ARB_OVF_EN
  output logic             carry,
`endif
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] w_b;

  assign w_b = shift ? (b << ADDER_BRANCH_SHIFT) : b;

`ifdef SHARED_ADDER_ARB_OVF_EN
  logic [WIDTH:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, w_b};
  assign sum    = w_full[WIDTH-1:0];
  // The MSB pushed out by the branch shift also counts as overflow.
  assign carry  = w_full[WIDTH] | (shift & b[WIDTH-1]);
`else
  assign sum = a + w_b;
`endif

endmodule

// File: rtl/shared_adder_arbiter.sv
// One adder shared by NUM_REQ round-robin requesters; one registered, tagged response slot.
// SHARED_ADDER_ARB_OVF_EN adds the rsp_ovf_o port (carry-out registered with the sum).
module shared_adder_arbiter
  import shared_adder_arb_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_data1_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data2_i,
  input  logic [NUM_REQ-1:0]       req_shift_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
`ifdef SHARED_ADDER_ARB_OVF_EN
  output logic                     rsp_ovf_o,
`endif
  output logic [ID_W-1:0]          rsp_id_o
);

  slot_state_t      r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_data;

  logic               w_free;
  logic               w_grant;
  logic               w_use_hi;
  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_sel;
  logic [NUM_REQ-1:0] w_oh;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_ptr_next;
  logic               w_shift;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_sum;

  logic [ID_W-1:0]  w_id_acc [NUM_REQ+1];
  logic [WIDTH-1:0] w_a_acc  [NUM_REQ+1];
  logic [WIDTH-1:0] w_b_acc  [NUM_REQ+1];

  assign w_free  = (r_state == ST_EMPTY) || rsp_ready_i;
  assign w_grant = rst_i && w_free && (|req_valid_i);

  // Prefer requesters at or above the pointer; otherwise wrap to the lowest valid one.
  assign w_use_hi = |w_hi;
  assign w_sel    = w_use_hi ? w_hi : req_valid_i;
  assign w_oh     = w_sel & (~w_sel + NUM_REQ'(1));

  assign w_id_acc[0] = '0;
  assign w_a_acc[0]  = '0;
  assign w_b_acc[0]  = '0;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_hi[gi]       = req_valid_i[gi] && (ID_W'(gi) >= r_ptr);
      assign w_id_acc[gi+1] = w_id_acc[gi] | (w_oh[gi] ? ID_W'(gi) : '0);
      assign w_a_acc[gi+1]  = w_a_acc[gi] | ({WIDTH{w_oh[gi]}} & req_data1_i[gi*WIDTH +: WIDTH]);
      assign w_b_acc[gi+1]  = w_b_acc[gi] | ({WIDTH{w_oh[gi]}} & req_data2_i[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  assign w_gnt_idx   = w_id_acc[NUM_REQ];
  assign w_a         = w_a_acc[NUM_REQ];
  assign w_b         = w_b_acc[NUM_REQ];
  assign w_shift     = |(w_oh & req_shift_i);
  assign req_ready_o = w_grant ? w_oh : '0;
  assign w_ptr_next  = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

`ifdef SHARED_ADDER_ARB_OVF_EN
  logic w_carry;
  logic r_ovf;

  arb_add_core #(.WIDTH(WIDTH)) u_core (
    .a     (w_a),
    .b     (w_b),
    .shift (w_shift),
    .carry (w_carry),
    .sum   (w_sum)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       r_ovf <= 1'b0;
    else if (w_grant) r_ovf <= w_carry;
  end

  assign rsp_ovf_o = r_ovf;
`else
  arb_add_core #(.WIDTH(WIDTH)) u_core (
    .a     (w_a),
    .b     (w_b),
    .shift (w_shift),
    .sum   (w_sum)
  );
`endif

  // A grant always refills the slot, so pop+grant in one cycle leaves no bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_grant) begin
            r_state <= ST_FULL;
            r_data  <= w_sum;
            r_id    <= w_gnt_idx;
            r_ptr   <= w_ptr_next;
          end
        end
        ST_FULL: begin
          if (w_grant) begin
            r_data <= w_sum;
            r_id   <= w_gnt_idx;
            r_ptr  <= w_ptr_next;
          end else if (rsp_ready_i) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign rsp_valid_o = (r_state == ST_FULL);
  assign rsp_data_o  = r_data;
  assign rsp_id_o    = r_id;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Scoreboard bench for shared_adder_arbiter (WIDTH=32, NUM_REQ=2); honours SHARED_ADDER_ARB_OVF_EN.
module tb_shared_adder_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_data1_i;
  logic [63:0] req_data2_i;
  logic [1:0]  req_shift_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [0:0]  rsp_id_o;
`ifdef SHARED_ADDER_ARB_OVF_EN
  logic        rsp_ovf_o;
`endif

  logic [31:0] tb_d1 [2];
  logic [31:0] tb_d2 [2];

  assign req_data1_i = {tb_d1[1], tb_d1[0]};
  assign req_data2_i = {tb_d2[1], tb_d2[0]};

  shared_adder_arbiter #(.WIDTH(32), .NUM_REQ(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data1_i (req_data1_i),
    .req_data2_i (req_data2_i),
    .req_shift_i (req_shift_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
`ifdef SHARED_ADDER_ARB_OVF_EN
    .rsp_ovf_o   (rsp_ovf_o),
`endif
    .rsp_id_o    (rsp_id_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  logic m_valid = 1'b0;
  logic m_ptr   = 1'b0;

  function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b, input logic sh);
    logic [31:0] bb;
    logic [32:0] s;
    bb = sh ? {b[30:0], 1'b0} : b;
    s = {1'b0, a} + {1'b0, bb};
    s[32] = s[32] | (sh & b[31]);
    return s;
  endfunction

  // Reference model: round-robin grant, response slot, expected-result queue.
  always @(negedge clk_i) begin
    logic        found;
    logic        g;
    logic        first;
    logic        second;
    logic        free;
    logic [1:0]  exp_rdy;
    logic [32:0] s;
    exp_t        e;
    if (!rst_i) begin
      sb.delete();
      m_valid = 1'b0;
      m_ptr   = 1'b0;
      chk_eq("rst_valid", 64'(rsp_valid_o), 64'(0));
      chk_eq("rst_ready", 64'(req_ready_o), 64'(0));
    end else begin
      chk_eq("rsp_valid", 64'(rsp_valid_o), 64'(m_valid));
      if (m_valid) begin
        if (sb.size() == 0) begin
          chk_eq("sb_underflow", 64'(sb.size()), 64'(1));
        end else begin
          chk_eq("rsp_data", 64'(rsp_data_o), 64'(sb[0].data));
          chk_eq("rsp_id", 64'(rsp_id_o), 64'(sb[0].id));
`ifdef SHARED_ADDER_ARB_OVF_EN
          chk_eq("rsp_ovf", 64'(rsp_ovf_o), 64'(sb[0].ovf));
`endif
          if (rsp_ready_i) begin
            $display("rsp id=%0d data=%h", sb[0].id, sb[0].data);
            void'(sb.pop_front());
          end
        end
      end
      free   = !m_valid || rsp_ready_i;
      first  = m_ptr;
      second = ~m_ptr;
      found  = 1'b0;
      g      = 1'b0;
      if (req_valid_i[first]) begin
        found = 1'b1;
        g     = first;
      end else if (req_valid_i[second]) begin
        found = 1'b1;
        g     = second;
      end
      exp_rdy = 2'b00;
      if (found && free) exp_rdy[g] = 1'b1;
      chk_eq("req_ready", 64'(req_ready_o), 64'(exp_rdy));
      if (found && free) begin
        s      = model_add(tb_d1[g], tb_d2[g], req_shift_i[g]);
        e.id   = g;
        e.data = s[31:0];
        e.ovf  = s[32];
        sb.push_back(e);
        m_ptr   = ~g;
        m_valid = 1'b1;
      end else if (rsp_ready_i) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] held;

  initial begin
    rst_i       = 1'b0;
    req_valid_i = 2'b00;
    req_shift_i = 2'b00;
    rsp_ready_i = 1'b1;
    tb_d1[0] = '0; tb_d1[1] = '0;
    tb_d2[0] = '0; tb_d2[1] = '0;
    repeat (3) step();
    chk_eq("reset_data", 64'(rsp_data_o), 64'(0));
    chk_eq("reset_id", 64'(rsp_id_o), 64'(0));
    rst_i = 1'b1;
    step();

    // single request, no shift
    tb_d1[0] = 32'd1000; tb_d2[0] = 32'd4; req_shift_i = 2'b00;
    req_valid_i = 2'b01;
    #1 chk_eq("t2_ready_same_cycle", 64'(req_ready_o), 64'(2'b01));
    step();
    req_valid_i = 2'b00;
    chk_eq("t2_valid", 64'(rsp_valid_o), 64'(1));
    chk_eq("t2_data", 64'(rsp_data_o), 64'(32'd1004));
    chk_eq("t2_id", 64'(rsp_id_o), 64'(0));

    // branch shift on requester 1, back-to-back with the previous pop
    tb_d1[1] = 32'h100; tb_d2[1] = 32'hFFFF_FFF8; req_shift_i = 2'b10;
    req_valid_i = 2'b10;
    step();
    req_valid_i = 2'b00;
    chk_eq("t3_data", 64'(rsp_data_o), 64'(32'hF0));
    chk_eq("t3_id", 64'(rsp_id_o), 64'(1));
`ifdef SHARED_ADDER_ARB_OVF_EN
    chk_eq("t3_ovf", 64'(rsp_ovf_o), 64'(1));
`endif

    // round robin with both requesters active
    tb_d1[0] = 32'd10; tb_d2[0] = 32'd20;
    tb_d1[1] = 32'd7;  tb_d2[1] = 32'd3;  req_shift_i = 2'b00;
    req_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_eq("t4_valid", 64'(rsp_valid_o), 64'(1));
      chk_eq("t4_id", 64'(rsp_id_o), 64'(i % 2));
    end
    req_valid_i = 2'b00;

    // wrap to zero
    tb_d1[0] = 32'hFFFF_FFFF; tb_d2[0] = 32'd1;
    req_valid_i = 2'b01;
    step();
    req_valid_i = 2'b00;
    chk_eq("t6_data", 64'(rsp_data_o), 64'(0));
    chk_eq("t6_id", 64'(rsp_id_o), 64'(0));
`ifdef SHARED_ADDER_ARB_OVF_EN
    chk_eq("t6_ovf", 64'(rsp_ovf_o), 64'(1));
`endif
    step();

    // backpressure: fill slot, then stall with a new request pending
    tb_d1[0] = 32'h1234; tb_d2[0] = 32'h10;
    req_valid_i = 2'b01;
    step();
    held = rsp_data_o;
    chk_eq("t5_first", 64'(held), 64'(32'h1244));
    rsp_ready_i = 1'b0;
    tb_d1[0] = 32'h5000; tb_d2[0] = 32'h0800; req_shift_i = 2'b01;
    #1 chk_eq("t5_ready_low", 64'(req_ready_o), 64'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq("t5_stall_ready", 64'(req_ready_o), 64'(0));
      chk_eq("t5_stall_data", 64'(rsp_data_o), 64'(held));
      chk_eq("t5_stall_valid", 64'(rsp_valid_o), 64'(1));
    end
    rsp_ready_i = 1'b1;
    #1 chk_eq("t5_release_ready", 64'(req_ready_o), 64'(2'b01));
    step();
    req_valid_i = 2'b00; req_shift_i = 2'b00;
    chk_eq("t5_no_bubble", 64'(rsp_valid_o), 64'(1));
    chk_eq("t5_new_data", 64'(rsp_data_o), 64'(32'h6000));

    // reset while a response is held; pointer sits at 1 beforehand
    tb_d1[0] = 32'd55; tb_d2[0] = 32'd45;
    req_valid_i = 2'b01;
    step();
    rsp_ready_i = 1'b0;
    chk_eq("t1_full", 64'(rsp_valid_o), 64'(1));
    #2 rst_i = 1'b0;
    #1;
    chk_eq("t1_valid_async", 64'(rsp_valid_o), 64'(0));
    chk_eq("t1_data_async", 64'(rsp_data_o), 64'(0));
    chk_eq("t1_ready_in_reset", 64'(req_ready_o), 64'(0));
    step();
    rst_i = 1'b1;
    rsp_ready_i = 1'b1;
    tb_d1[1] = 32'd1; tb_d2[1] = 32'd2;
    req_valid_i = 2'b11;
    #1 chk_eq("t1_first_grant", 64'(req_ready_o), 64'(2'b01));
    step();
    req_valid_i = 2'b00;
    chk_eq("t1_id", 64'(rsp_id_o), 64'(0));
    chk_eq("t1_data", 64'(rsp_data_o), 64'(32'd100));

    repeat (3) step();
    chk_eq("sb_drained", 64'(sb.size()), 64'(0));
    chk_eq("idle_valid", 64'(rsp_valid_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
